// File: rtl/pulse_timer.sv
// pulse_timer: programmable periodic / one-shot pulse generator on a prescaled base tick.
// Optional feature macro: PULSE_TIMER_PRESCALE_EN (prescaler present); undefined means
// every RUN cycle is a base tick and PRE_DIV has no effect.
// Ports:
//   Clk, Reset        - clock, asynchronous active-high reset
//   Start, Stop       - start/restart and stop requests (Stop wins)
//   Mode              - 0 periodic, 1 one-shot (latched on accepted Start)
//   Period, Width     - base ticks per cycle / ClkOut high time (latched on accepted Start)
//   ClkOut            - registered pulse output
//   Busy              - high while running
//   Done              - one-cycle cycle-complete strobe
//   Err               - one-cycle strobe for a Start with Period == 0
//   Count             - base-tick index within the current cycle
module pulse_timer #(
  parameter int unsigned PRE_DIV  = 100000,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Stop,
  input  logic                Mode,
  input  logic [PERIOD_W-1:0] Period,
  input  logic [PERIOD_W-1:0] Width,
  output logic                ClkOut,
  output logic                Busy,
  output logic                Done,
  output logic                Err,
  output logic [PERIOD_W-1:0] Count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic                mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] width_q, width_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic                clk_out_q, clk_out_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                tick_c;
  logic                start_ok_c;
  logic [PERIOD_W:0]   thresh_c;

  // A Start is accepted only without Stop and with a non-zero period.
  assign start_ok_c = Start && !Stop && (Period != '0);

`ifdef PULSE_TIMER_PRESCALE_EN
  localparam int unsigned   PRE_W    = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  // Prescaler runs only in RUN; Stop and restart clear it, discarding a coincident tick.
  always_comb begin
    pre_d  = '0;
    tick_c = (state_q == RUN) && (pre_q == PRE_LAST);
    if ((state_q == RUN) && !Stop && !start_ok_c && !tick_c) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  // No prescaler: every RUN cycle is a base tick.
  assign tick_c = (state_q == RUN);

  // PRE_DIV is intentionally inert in this build.
  if (PRE_DIV == 0) begin : g_pre_div_unused
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    width_d  = width_q;
    count_d  = count_q;
    done_d   = 1'b0;
    err_d    = Start && !Stop && (Period == '0);

    if (Stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start_ok_c) begin
      state_d  = RUN;
      mode_d   = Mode;
      period_d = Period;
      width_d  = Width;
      count_d  = '0;
    end else if ((state_q == RUN) && tick_c) begin
      if (count_q == period_q - PERIOD_W'(1)) begin
        count_d = '0;
        done_d  = 1'b1;
        if (mode_q) begin
          state_d = IDLE;
        end
      end else begin
        count_d = count_q + PERIOD_W'(1);
      end
    end

    // Borrow out of the wide subtraction means Width > Period: output held high.
    thresh_c  = {1'b0, period_d} - {1'b0, width_d};
    clk_out_d = (state_d == RUN) && (thresh_c[PERIOD_W] || ({1'b0, count_d} >= thresh_c));
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      period_q  <= '0;
      width_q   <= '0;
      count_q   <= '0;
      clk_out_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      width_q   <= width_d;
      count_q   <= count_d;
      clk_out_q <= clk_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ClkOut = clk_out_q;
  assign Busy   = (state_q == RUN);
  assign Done   = done_q;
  assign Err    = err_q;
  assign Count  = count_q;

endmodule

// File: tb/tb_pulse_timer.sv
module tb_pulse_timer;

  localparam int unsigned PW = 8;
`ifdef PULSE_TIMER_PRESCALE_EN
  localparam int TPB = 4;   // Clk cycles per base tick
`else
  localparam int TPB = 1;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          Stop = 1'b0;
  logic          Mode = 1'b0;
  logic [PW-1:0] Period = '0;
  logic [PW-1:0] Width = '0;
  logic          ClkOut, Busy, Done, Err;
  logic [PW-1:0] Count;

  int n_assert = 0;
  int n_fail   = 0;

  pulse_timer #(.PRE_DIV(4), .PERIOD_W(PW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Mode(Mode),
    .Period(Period), .Width(Width), .ClkOut(ClkOut), .Busy(Busy),
    .Done(Done), .Err(Err), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_run(input logic m, input int p, input int w);
    Start = 1'b1; Mode = m; Period = PW'(p); Width = PW'(w);
    step();
    Start = 1'b0; Mode = 1'b0; Period = '0; Width = '0;
  endtask

  task automatic stop_run();
    Stop = 1'b1;
    step();
    Stop = 1'b0;
  endtask

  task automatic wait_count(input int v);
    int budget;
    budget = 200;
    while (Count != PW'(v) && budget > 0) begin
      step();
      budget--;
    end
    chk("wait_count", 32'(Count), 32'(v));
  endtask

  initial begin
    int hi, dn, exp_c;
    logic bad;

    // Reset state
    #12;
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_clkout", 32'(ClkOut), 0);
    chk("rst_count", 32'(Count), 0);
    chk("rst_done_err", 32'({Done, Err}), 0);
    Reset = 1'b0;
    step();

    // Period == 0 is rejected with a single Err strobe
    start_run(1'b0, 0, 2);
    chk("p0_err", 32'(Err), 1);
    chk("p0_busy", 32'(Busy), 0);
    step();
    chk("p0_err_clear", 32'(Err), 0);

    // Start with Stop in IDLE: nothing happens
    Start = 1'b1; Stop = 1'b1; Period = 8'd5;
    step();
    Start = 1'b0; Stop = 1'b0; Period = '0;
    chk("ss_busy", 32'(Busy), 0);
    chk("ss_err", 32'(Err), 0);

    // Periodic P=5 W=2 over two cycles
    start_run(1'b0, 5, 2);
    hi = 0; dn = 0; bad = 1'b0;
    for (int k = 0; k < 10 * TPB; k++) begin
      exp_c = (k / TPB) % 5;
      if (Count != PW'(exp_c) || ClkOut != (exp_c >= 3) || Busy != 1'b1 ||
          Done != (k > 0 && k % (5 * TPB) == 0)) bad = 1'b1;
      hi += int'(ClkOut);
      dn += int'(Done);
      step();
    end
    chk("per_cycle_trace", 32'(bad), 0);
    chk("per_clkout_high", 32'(hi), 32'(4 * TPB));
    chk("per_done_cnt", 32'(dn), 1);
    chk("per_done_wrap", 32'(Done), 1);

    // Stop at Count=3: cleared next cycle, no Done
    wait_count(3);
    stop_run();
    chk("stop_busy", 32'(Busy), 0);
    chk("stop_count", 32'(Count), 0);
    chk("stop_clkout", 32'(ClkOut), 0);
    chk("stop_done", 32'(Done), 0);

    // One-shot P=3 W=1
    start_run(1'b1, 3, 1);
    hi = 0; bad = 1'b0;
    for (int k = 0; k < 3 * TPB; k++) begin
      if (Busy != 1'b1 || Done != 1'b0 || Count != PW'(k / TPB) ||
          ClkOut != (k / TPB == 2)) bad = 1'b1;
      hi += int'(ClkOut);
      step();
    end
    chk("os_trace", 32'(bad), 0);
    chk("os_clkout_high", 32'(hi), 32'(TPB));
    chk("os_done", 32'(Done), 1);
    chk("os_busy_fall", 32'(Busy), 0);
    chk("os_end_count", 32'(Count), 0);
    step();
    chk("os_done_once", 32'(Done), 0);

    // Width = 0: ClkOut never high
    start_run(1'b0, 3, 0);
    hi = 0;
    for (int k = 0; k < 6 * TPB; k++) begin
      hi += int'(ClkOut);
      step();
    end
    chk("w0_clkout", 32'(hi), 0);
    stop_run();

    // Width > Period: ClkOut tracks Busy from the first cycle
    start_run(1'b0, 5, 7);
    bad = 1'b0;
    for (int k = 0; k < 5 * TPB + 2; k++) begin
      if (ClkOut != Busy || Busy != 1'b1) bad = 1'b1;
      step();
    end
    chk("wbig_clkout_eq_busy", 32'(bad), 0);
    stop_run();
    chk("wbig_stop_clkout", 32'(ClkOut), 0);

    // Restart behaviour: Period=0 errs without disturbing the run; valid Start relatches
    start_run(1'b0, 5, 2);
    wait_count(2);
    Start = 1'b1; Period = '0;
    step();
    Start = 1'b0;
    chk("rs_err", 32'(Err), 1);
    chk("rs_busy_kept", 32'(Busy), 1);
    start_run(1'b0, 4, 4);
    chk("rs_count_clr", 32'(Count), 0);
    chk("rs_no_done", 32'(Done), 0);
    chk("rs_relatched_w", 32'(ClkOut), 1);
    stop_run();

    // Period=4 Width=1: one Done per 4 base ticks, ClkOut at Count 3
    start_run(1'b0, 4, 1);
    hi = 0; dn = 0;
    for (int k = 0; k < 8 * TPB; k++) begin
      hi += int'(ClkOut);
      dn += int'(Done);
      step();
    end
    chk("p4_clkout_high", 32'(hi), 32'(2 * TPB));
    chk("p4_done_cnt", 32'(dn), 1);
    chk("p4_done_wrap", 32'(Done), 1);
    stop_run();

    // Asynchronous reset between edges at Count=4
    start_run(1'b0, 5, 2);
    wait_count(4);
    chk("ar_pre_clkout", 32'(ClkOut), 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("ar_outputs", 32'({ClkOut, Busy, Done, Err}), 0);
    chk("ar_count", 32'(Count), 0);
    #1;
    Reset = 1'b0;
    start_run(1'b0, 3, 1);
    chk("ar_restart_busy", 32'(Busy), 1);
    chk("ar_restart_count", 32'(Count), 0);
    stop_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_timer.md
PULSE_TIMER -- requirements
Module: pulse_timer

Interface
REQ-001 SHALL have parameter PRE_DIV, default 100000, base-tick prescale divisor in Clk cycles (>=1; 1 kHz base tick at 100 MHz).
REQ-002 SHALL have parameter PERIOD_W, default 16, width of Period, Width and Count.
REQ-003 SHALL have port Clk  input  1  single system clock; all state changes on posedge Clk.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  start/restart request, sampled each posedge.
REQ-006 SHALL have port Stop  input  1  stop request, sampled each posedge.
REQ-007 SHALL have port Mode  input  1  0 = periodic, 1 = one-shot; latched on accepted Start.
REQ-008 SHALL have port Period  input  PERIOD_W  base ticks per cycle; latched on accepted Start.
REQ-009 SHALL have port Width  input  PERIOD_W  ClkOut high time in base ticks; latched on accepted Start.
REQ-010 SHALL have port ClkOut  output  1  registered pulse output.
REQ-011 SHALL have port Busy  output  1  high while running.
REQ-012 SHALL have port Done  output  1  one-Clk-cycle cycle-complete strobe.
REQ-013 SHALL have port Err  output  1  one-Clk-cycle strobe for a rejected Start.
REQ-014 SHALL have port Count  output  PERIOD_W  current base-tick index within the cycle.

Function
REQ-015 SHALL implement two states, IDLE and RUN; internal prescaler width = ceil(log2(PRE_DIV)), minimum 1.
REQ-016 In IDLE, Start=1, Stop=0 and Period!=0 SHALL latch Mode/Period/Width, enter RUN, and clear prescaler and Count at the same edge; Busy=1 from the next cycle.
REQ-017 Start=1 with Period==0 SHALL be rejected: no state change, Err=1 for one cycle.
REQ-018 In RUN, the prescaler SHALL count 0..PRE_DIV-1 and wrap; a base tick occurs at each edge where the prescaler equals PRE_DIV-1.
REQ-019 On each base tick, Count SHALL increment; when Count==Period_l-1 it wraps to 0 instead.
REQ-020 Periodic wrap SHALL keep RUN and set Done=1 for the first cycle Count is 0 again.
REQ-021 One-shot wrap SHALL go to IDLE, clear Count, Busy and ClkOut, and set Done=1 in that same cycle.
REQ-022 ClkOut SHALL be registered and equal 1 exactly in cycles where Busy=1 and Count >= Period_l-Width_l, with the subtraction in PERIOD_W+1 bits.
REQ-023 Width_l==0 SHALL keep ClkOut at 0; Width_l>=Period_l SHALL hold ClkOut at 1 for the whole of RUN.
REQ-024 Stop=1 SHALL force IDLE at the next edge, clearing Count, prescaler and ClkOut, with no Done.
REQ-025 Stop SHALL have priority over simultaneous Start.
REQ-026 Start in RUN with Period!=0 SHALL restart: relatch inputs, clear counters, no Done; with Period==0 it SHALL give Err and leave the run unaffected.
REQ-027 A base tick coinciding with Stop or restart SHALL be discarded.
REQ-028 Inputs other than Start/Stop SHALL be ignored except at an accepted Start.

Reset
REQ-029 Reset=1 SHALL asynchronously force IDLE with prescaler, Count, latched registers, ClkOut, Busy, Done and Err at 0, mid-run included.
REQ-030 After Reset deasserts, the first edge SHALL accept Start normally.

Configuration
REQ-031 With macro PULSE_TIMER_PRESCALE_EN defined, the prescaler SHALL be present and operate per REQ-018.
REQ-032 Without PULSE_TIMER_PRESCALE_EN, the prescaler SHALL be omitted, every RUN cycle SHALL be a base tick, and PRE_DIV SHALL be ignored (simulation-speed build).

Verification (PRE_DIV=4, PERIOD_W=8, macro defined unless noted)
REQ-033 Periodic, Period=5, Width=2, one-cycle Start: ClkOut high 8 of every 20 Clk cycles (Count 3..4); Done every 20 cycles; Busy held.
REQ-034 One-shot, Period=3, Width=1: ClkOut high 4 cycles (Count=2); Done once, 12 cycles after Busy rises, with Busy falling together.
REQ-035 Start with Period=0: Err=1 for one cycle, Busy stays 0; Width=0: ClkOut never high; Width=7, Period=5: ClkOut == Busy.
REQ-036 Start and Stop together in IDLE: stays IDLE, no Err; Stop at Count=3: Busy=0, Count=0, ClkOut=0 next cycle, no Done.
REQ-037 Reset pulsed between clock edges at Count=4: all outputs 0 before the next posedge.
REQ-038 Macro undefined, Period=4, Width=1: Done every 4 cycles; ClkOut high 1 of every 4 cycles.
